// File: rtl/bloom_filter_shifter_pkg.sv
// Shared definitions for the Bloom filter aging engine: FSM encoding,
// generation geometry defaults and small arithmetic helpers.
package bloom_filter_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD       = 2'd1,
    ST_WAIT_VLD = 2'd2,
    ST_WR       = 2'd3
  } state_e;

  localparam int GEN_WIDTH_DEF = 9;
  localparam int SDW_DEF       = 36;
  localparam int NUM_GENS      = SDW_DEF / GEN_WIDTH_DEF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bloom_filter_shifter_if.sv
// Read/write requester port pair toward the SRAM arbiter (rd_1 / wr_1).
interface bloom_filter_shifter_if #(
  parameter int SAW = 19,
  parameter int SDW = 36
);
  logic           rd_req;
  logic [SAW-1:0] rd_addr;
  logic           rd_ack;
  logic           rd_vld;
  logic [SDW-1:0] rd_data;
  logic           wr_req;
  logic [SAW-1:0] wr_addr;
  logic [SDW-1:0] wr_data;
  logic           wr_ack;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, rd_vld, rd_data, wr_ack
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, rd_vld, rd_data, wr_ack
  );
endinterface

// File: rtl/bloom_filter_shifter_sweep_timer.sv
// Periodic sweep timer merged with the software start pulse into one trigger.
module bloom_filter_shifter_sweep_timer
  import bloom_filter_shifter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sweep_period,
  input  logic        sweep_start,
  output logic        trigger
);

  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;
  logic        fire_s;

  // The active period is only re-sampled at a reload, or continuously while disabled.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    fire_s   = 1'b0;
    if (period_q == 32'd0) begin
      period_d = sweep_period;
      count_d  = 32'd0;
    end else if (count_q == period_q - 32'd1) begin
      fire_s   = 1'b1;
      count_d  = 32'd0;
      period_d = sweep_period;
    end else begin
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 32'd0;
      period_q <= 32'd0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  assign trigger = fire_s | sweep_start;

endmodule

// File: rtl/bloom_filter_shifter.sv
// Aging engine: sweeps every SRAM word through read-shift-write, moving each
// generation slice up by one and clearing the newest slice.
module bloom_filter_shifter
  import bloom_filter_shifter_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = SDW_DEF,
  parameter int GEN_WIDTH       = GEN_WIDTH_DEF,
  parameter int NUM_WORDS       = 2**19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arb_enable,
  input  logic [31:0]             sweep_period,
  input  logic                    sweep_start,
  bloom_filter_shifter_if.master  mem,
  output logic                    sweep_busy,
  output logic                    sweep_done,
  output logic [31:0]             sweep_count,
  output logic [15:0]             sweep_overrun
);

  localparam int SAW = SRAM_ADDR_WIDTH;
  localparam int SDW = SRAM_DATA_WIDTH;
  localparam logic [SAW-1:0] LAST_ADDR = SAW'(NUM_WORDS - 1);

  state_e         state_q, state_d;
  logic [SAW-1:0] addr_q, addr_d;
  logic [SDW-1:0] wr_data_q, wr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    count_q, count_d;
  logic [15:0]    overrun_q, overrun_d;
  logic           trigger_s;

  bloom_filter_shifter_sweep_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .sweep_period (sweep_period),
    .sweep_start  (sweep_start),
    .trigger      (trigger_s)
  );

  // Sweep sequencing, one word in flight, plus trigger bookkeeping.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s && arb_enable) begin
          state_d = ST_RD;
          addr_d  = {SAW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem.rd_ack) state_d = ST_WAIT_VLD;
        else            state_d = ST_RD;
      end
      ST_WAIT_VLD: begin
        if (mem.rd_vld) begin
          state_d   = ST_WR;
          wr_data_d = {mem.rd_data[SDW-GEN_WIDTH-1:0], {GEN_WIDTH{1'b0}}};
        end else begin
          state_d   = ST_WAIT_VLD;
        end
      end
      ST_WR: begin
        if (mem.wr_ack && (addr_q == LAST_ADDR)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          count_d = count_q + 32'd1;
          busy_d  = 1'b0;
        end else if (mem.wr_ack) begin
          state_d = ST_RD;
          addr_d  = addr_q + SAW'(1);
        end else begin
          state_d = ST_WR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (trigger_s && (busy_q || !arb_enable)) overrun_d = sat_inc16(overrun_q);
    else                                      overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= {SAW{1'b0}};
      wr_data_q <= {SDW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 32'd0;
      overrun_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // The arbiter re-samples req in the ack cycle, so ack must drop req combinationally.
  assign mem.rd_req  = (state_q == ST_RD) & ~mem.rd_ack & arb_enable;
  assign mem.wr_req  = (state_q == ST_WR) & ~mem.wr_ack & arb_enable;
  assign mem.rd_addr = addr_q;
  assign mem.wr_addr = addr_q;
  assign mem.wr_data = wr_data_q;

  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;
  assign sweep_count   = count_q;
  assign sweep_overrun = overrun_q;

endmodule

// File: tb/tb_bloom_filter_shifter.sv
// Self-checking bench: arbiter/SRAM model with random grant stalls and an
// arithmetic aging reference, plus directed corner-case sequences.
module tb_bloom_filter_shifter;

  localparam int SAW = 19;
  localparam int SDW = 36;
  localparam int GW  = 9;
  localparam int NW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arb_enable = 1'b0;
  logic        sweep_start = 1'b0;
  logic [31:0] sweep_period = 32'd0;
  logic        sweep_busy, sweep_done;
  logic [31:0] sweep_count;
  logic [15:0] sweep_overrun;

  bloom_filter_shifter_if #(.SAW(SAW), .SDW(SDW)) bus ();

  bloom_filter_shifter #(
    .SRAM_ADDR_WIDTH (SAW),
    .SRAM_DATA_WIDTH (SDW),
    .GEN_WIDTH       (GW),
    .NUM_WORDS       (NW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .arb_enable    (arb_enable),
    .sweep_period  (sweep_period),
    .sweep_start   (sweep_start),
    .mem           (bus),
    .sweep_busy    (sweep_busy),
    .sweep_done    (sweep_done),
    .sweep_count   (sweep_count),
    .sweep_overrun (sweep_overrun)
  );

  always #5 clk = ~clk;

  // Arbiter / SRAM model state (owned by the monitor process).
  logic [SDW-1:0] mem [NW];
  logic [SDW-1:0] load_vals [NW];
  logic           load_mem = 1'b0;
  int             grant_pct = 100;
  int reads = 0, writes = 0, dbl_grant = 0, gate_err = 0, addr_err = 0;
  int done_pulses = 0, vld_pulses = 0, cyc = 0, vld_cnt = 0, next_addr = 0;
  int rise_cyc [$];
  logic [SAW-1:0] vld_addr = '0, last_rd = '0;
  logic busy_prev = 1'b0;

  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_vld  = 1'b0;
    bus.rd_data = '0;
    bus.wr_ack  = 1'b0;
  end

  // Lowest-priority arbiter: grants a sampled req at random, rd_vld 3 cycles after rd_ack.
  always @(negedge clk) begin
    cyc++;
    if (load_mem) for (int i = 0; i < NW; i++) mem[i] = load_vals[i];
    if (bus.rd_ack && bus.rd_req) dbl_grant++;
    if (bus.wr_ack && bus.wr_req) dbl_grant++;
    if (!arb_enable && (bus.rd_req || bus.wr_req)) gate_err++;
    if (sweep_done) done_pulses++;
    if (sweep_busy && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = sweep_busy;
    if (reset) next_addr = 0;
    bus.rd_vld = 1'b0;
    if (vld_cnt > 0) begin
      vld_cnt--;
      if (vld_cnt == 0) begin
        bus.rd_vld  = 1'b1;
        bus.rd_data = mem[vld_addr[1:0]];
        vld_pulses++;
      end
    end
    if (!bus.rd_ack && bus.rd_req && (int'($urandom_range(99)) < grant_pct)) begin
      bus.rd_ack = 1'b1;
      reads++;
      if (int'(bus.rd_addr) != next_addr) addr_err++;
      last_rd  = bus.rd_addr;
      vld_addr = bus.rd_addr;
      vld_cnt  = 3;
    end else begin
      bus.rd_ack = 1'b0;
    end
    if (!bus.wr_ack && bus.wr_req && (int'($urandom_range(99)) < grant_pct)) begin
      bus.wr_ack = 1'b1;
      writes++;
      if (bus.wr_addr != last_rd || int'(bus.wr_addr) >= NW) addr_err++;
      mem[bus.wr_addr[1:0]] = bus.wr_data;
      next_addr = (int'(last_rd) + 1) % NW;
    end else begin
      bus.wr_ack = 1'b0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each sweep multiplies the word by 2^GW modulo 2^SDW.
  function automatic logic [SDW-1:0] age(input logic [SDW-1:0] w, input int n);
    logic [63:0] v;
    v = 64'(w);
    for (int k = 0; k < n; k++) v = (v * 64'd512) % (64'd1 << SDW);
    return SDW'(v);
  endfunction

  task automatic load(input logic [SDW-1:0] v0, v1, v2, v3);
    load_vals[0] = v0; load_vals[1] = v1; load_vals[2] = v2; load_vals[3] = v3;
    load_mem = 1'b1;
    @(negedge clk);
    #1;
    load_mem = 1'b0;
  endtask

  task automatic pulse_start();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int k;
    d0 = done_pulses;
    k  = 0;
    while (done_pulses == d0 && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("%s sweep_done seen", name), 64'(done_pulses - d0), 64'd1);
  endtask

  typedef struct {
    logic [SDW-1:0] preset;
    logic [SDW-1:0] expect_v;
  } vec_t;

  vec_t vecs [NW];
  logic [SDW-1:0] rv [NW];
  logic [SDW-1:0] ex [NW];
  int r0, w0, d0, v0, c0, nsw;

  initial begin
    vecs[0] = '{36'h1_2345_6789, 36'h6_8ACF_1200};
    vecs[1] = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FE00};
    vecs[2] = '{36'h0_0000_01FF, 36'h0_0003_FE00};
    vecs[3] = '{36'h8_0000_0000, 36'h0_0000_0000};

    repeat (3) tick();
    check("reset busy",    64'(sweep_busy),    64'd0);
    check("reset done",    64'(sweep_done),    64'd0);
    check("reset count",   64'(sweep_count),   64'd0);
    check("reset overrun", 64'(sweep_overrun), 64'd0);
    check("reset rd_req",  64'(bus.rd_req),    64'd0);
    check("reset wr_req",  64'(bus.wr_req),    64'd0);
    check("reset wr_data", 64'(bus.wr_data),   64'd0);
    reset = 1'b0;
    arb_enable = 1'b1;
    tick();

    // Table-driven single sweep.
    load(vecs[0].preset, vecs[1].preset, vecs[2].preset, vecs[3].preset);
    r0 = reads; w0 = writes; d0 = done_pulses;
    pulse_start();
    wait_done("table", 400);
    repeat (5) tick();
    for (int i = 0; i < NW; i++) check($sformatf("table word%0d", i), 64'(mem[i]), 64'(vecs[i].expect_v));
    check("table done pulses", 64'(done_pulses - d0), 64'd1);
    check("table count",       64'(sweep_count),      64'd1);
    check("table reads",       64'(reads - r0),       64'd4);
    check("table writes",      64'(writes - w0),      64'd4);
    check("table busy after",  64'(sweep_busy),       64'd0);

    // Random data with stalling arbiter, one or two sweeps.
    grant_pct = 35;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NW; i++) rv[i] = SDW'({$urandom(), $urandom()});
      load(rv[0], rv[1], rv[2], rv[3]);
      nsw = (it % 2) + 1;
      c0 = int'(sweep_count); r0 = reads; w0 = writes;
      for (int s = 0; s < nsw; s++) begin
        pulse_start();
        wait_done($sformatf("rand%0d", it), 2000);
        tick();
      end
      for (int i = 0; i < NW; i++) begin
        ex[i] = age(rv[i], nsw);
        check($sformatf("rand%0d word%0d", it, i), 64'(mem[i]), 64'(ex[i]));
      end
      check($sformatf("rand%0d count", it),  64'(sweep_count), 64'(c0 + nsw));
      check($sformatf("rand%0d reads", it),  64'(reads - r0),  64'(4 * nsw));
      check($sformatf("rand%0d writes", it), 64'(writes - w0), 64'(4 * nsw));
    end
    check("no double grant", 64'(dbl_grant), 64'd0);
    check("address order",   64'(addr_err),  64'd0);

    // Start request while busy is dropped and counted.
    grant_pct = 60;
    c0 = int'(sweep_count); r0 = reads; d0 = done_pulses;
    pulse_start();
    repeat (3) tick();
    check("busy mid sweep", 64'(sweep_busy), 64'd1);
    pulse_start();
    tick();
    check("overrun busy", 64'(sweep_overrun), 64'd1);
    wait_done("overrun", 1000);
    repeat (30) tick();
    check("overrun single sweep", 64'(done_pulses - d0), 64'd1);
    check("overrun count",        64'(sweep_count),      64'(c0 + 1));
    check("overrun reads",        64'(reads - r0),       64'd4);
    check("overrun addr order",   64'(addr_err),         64'd0);

    // arb_enable drops mid-sweep: reqs gated, sweep resumes.
    grant_pct = 100;
    for (int i = 0; i < NW; i++) rv[i] = SDW'({$urandom(), $urandom()});
    load(rv[0], rv[1], rv[2], rv[3]);
    r0 = reads;
    pulse_start();
    for (int k = 0; k < 200 && reads - r0 < 2; k++) tick();
    arb_enable = 1'b0;
    w0 = reads;
    repeat (15) tick();
    check("disabled no reads",  64'(reads - w0), 64'd0);
    check("disabled busy held", 64'(sweep_busy), 64'd1);
    arb_enable = 1'b1;
    wait_done("resume", 400);
    for (int i = 0; i < NW; i++) check($sformatf("resume word%0d", i), 64'(mem[i]), 64'(age(rv[i], 1)));
    check("gate errors", 64'(gate_err), 64'd0);

    // Trigger with arbiter not ready: no request, counted as dropped.
    arb_enable = 1'b0;
    r0 = reads;
    pulse_start();
    repeat (20) tick();
    check("noarb overrun", 64'(sweep_overrun), 64'd2);
    check("noarb busy",    64'(sweep_busy),    64'd0);
    check("noarb reads",   64'(reads - r0),    64'd0);
    check("noarb gate",    64'(gate_err),      64'd0);
    arb_enable = 1'b1;
    tick();

    // Reset while waiting for read data; late rd_vld must be ignored.
    r0 = reads; w0 = writes; v0 = vld_pulses;
    pulse_start();
    for (int k = 0; k < 50 && reads == r0; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst busy",    64'(sweep_busy),    64'd0);
    check("rst count",   64'(sweep_count),   64'd0);
    check("rst overrun", 64'(sweep_overrun), 64'd0);
    check("rst rd_req",  64'(bus.rd_req),    64'd0);
    repeat (20) tick();
    check("rst late vld delivered", 64'(vld_pulses - v0), 64'd1);
    check("rst no write",           64'(writes - w0),     64'd0);
    check("rst stays idle",         64'(sweep_busy),      64'd0);
    check("rst wr_req",             64'(bus.wr_req),      64'd0);

    // Periodic timer: launches every 100 cycles, then disabled.
    r0 = rise_cyc.size();
    sweep_period = 32'd100;
    repeat (450) tick();
    check("timer launches", 64'(rise_cyc.size() - r0), 64'd4);
    for (int i = r0 + 1; i < rise_cyc.size(); i++)
      check($sformatf("timer interval %0d", i - r0), 64'(rise_cyc[i] - rise_cyc[i-1]), 64'd100);
    check("timer overrun", 64'(sweep_overrun), 64'd0);
    sweep_period = 32'd0;
    repeat (150) tick();
    r0 = rise_cyc.size();
    repeat (300) tick();
    check("timer disabled", 64'(rise_cyc.size() - r0), 64'd0);
    check("final gate",     64'(gate_err),  64'd0);
    check("final dbl",      64'(dbl_grant), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
